// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the register-file write port, merging
// single-cycle ALU results with queued multi-cycle load results, and
// keeps the per-register pending-load scoreboard read by decode.
module wb_arbiter #(
    parameter int REGFILE_SIZE = 32,
    parameter int DEPTH        = 4,
    parameter int CNT_W        = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    AluValid,
    input  logic [4:0]              AluDest,
    input  logic [31:0]             AluData,
    input  logic                    MemValid,
    output logic                    MemReady,
    input  logic [4:0]              MemDest,
    input  logic [31:0]             MemData,
    input  logic                    IssueValid,
    input  logic [4:0]              IssueDest,
    output logic [REGFILE_SIZE-1:0] Busy,
    output logic                    WE,
    output logic [4:0]              Waddr,
    output logic [31:0]             Wdata,
    output logic [CNT_W-1:0]        Count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    logic [4:0]              dest_mem_q [DEPTH];
    logic [31:0]             data_mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [REGFILE_SIZE-1:0] busy_q, busy_d;
    logic                    we_q, we_d;
    logic [4:0]              waddr_q, waddr_d;
    logic [31:0]             wdata_q, wdata_d;

    logic       push;
    logic       pop;
    logic [4:0] head_dest;
    logic [31:0] head_data;

    // Ready only looks at occupancy: a same-cycle pop never frees a slot early.
    assign MemReady  = !RST && (count_q != FULL_CNT);
    assign push      = MemValid && MemReady;
    assign pop       = !AluValid && (count_q != '0);
    assign head_dest = dest_mem_q[rd_ptr_q];
    assign head_data = data_mem_q[rd_ptr_q];

    // Next-state for FIFO bookkeeping, write port and scoreboard.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        busy_d   = busy_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // ALU results cannot stall, so they always win the write port.
        if (AluValid) begin
            we_d    = (AluDest != 5'd0);
            waddr_d = AluDest;
            wdata_d = AluData;
        end else if (pop) begin
            we_d    = (head_dest != 5'd0);
            waddr_d = head_dest;
            wdata_d = head_data;
        end

        // Clear first so a same-register issue in this cycle re-sets the bit.
        if (pop) begin
            busy_d[head_dest] = 1'b0;
        end
        if (IssueValid && (IssueDest != 5'd0)) begin
            busy_d[IssueDest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= '0;
            we_q     <= 1'b0;
            waddr_q  <= 5'd0;
            wdata_q  <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO storage; contents are invalidated by the pointers, not cleared.
    always_ff @(posedge CLK) begin
        if (push) begin
            dest_mem_q[wr_ptr_q] <= MemDest;
            data_mem_q[wr_ptr_q] <= MemData;
        end
    end

    assign Busy  = busy_q;
    assign WE    = we_q;
    assign Waddr = waddr_q;
    assign Wdata = wdata_q;
    assign Count = count_q;

endmodule
